// File: rtl/space_race_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : space_race_pkg
// Description : Shared coin scheduler FSM state type and default timing values.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
package space_race_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } coin_state_t;

    // 10.5 ms high, 21 ms guard at 57.272 MHz
    localparam int COIN_PULSE_CNT = 600000;
    localparam int COIN_GAP_CNT   = 1200000;

endpackage
`default_nettype wire

// File: rtl/coin_debounce.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : coin_debounce
// Description : 1-bit level debouncer; present only when COIN_DEBOUNCE_EN is set.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`ifdef COIN_DEBOUNCE_EN
module coin_debounce #(
    parameter int DEB_CNT = 57272
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic din,
    output logic dout
);

    localparam int                 c_cnt_w = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(DEB_CNT - 1);

    logic [c_cnt_w-1:0] r_cnt;
    logic               r_level;

    // The counter only advances while the input disagrees with the held level
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else if (din == r_level) begin
            r_cnt <= '0;
        end else if (r_cnt == c_last) begin
            r_level <= din;
            r_cnt   <= '0;
        end else begin
            r_cnt <= r_cnt + c_cnt_w'(1);
        end
    end

    assign dout = r_level;

endmodule
`endif
`default_nettype wire

// File: rtl/coin_sched.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : coin_sched
// Description : Queues coin presses and replays them as timed COIN_SW pulses,
//               gating START_GAME around them. COIN_DEBOUNCE_EN adds debouncers.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module coin_sched
    import space_race_pkg::*;
#(
    parameter int PULSE_CNT   = COIN_PULSE_CNT,
    parameter int GAP_CNT     = COIN_GAP_CNT,
    parameter int QUEUE_DEPTH = 4,
    parameter int DEB_CNT     = 57272
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic [1:0] coin_in,
    input  logic [1:0] start_in,
    input  logic       credit_light_n,
    output logic       coin_sw,
    output logic       start_game,
    output logic [2:0] pending,
    output logic       overflow
);

    localparam int                 c_cnt_max   = (PULSE_CNT > GAP_CNT) ? PULSE_CNT : GAP_CNT;
    localparam int                 c_cnt_w     = (c_cnt_max > 1) ? $clog2(c_cnt_max) : 1;
    localparam logic [c_cnt_w-1:0] c_pulse_last = c_cnt_w'(PULSE_CNT - 1);
    localparam logic [c_cnt_w-1:0] c_gap_last   = c_cnt_w'(GAP_CNT - 1);
    localparam logic [3:0]         c_depth      = 4'(QUEUE_DEPTH);

    if (QUEUE_DEPTH < 1 || QUEUE_DEPTH > 7 || DEB_CNT < 1) begin : g_bad_param
        $error("coin_sched: QUEUE_DEPTH must be 1..7 and DEB_CNT at least 1");
    end

    logic [1:0]         w_coin_lvl;
    logic [1:0]         r_coin_prev;
    logic [1:0]         w_rise;
    logic               w_launch;
    logic [3:0]         w_q_sum;
    logic [2:0]         r_q;
    logic               r_overflow;
    coin_state_t        r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_coin_sw;
    logic               r_start_game;

`ifdef COIN_DEBOUNCE_EN
    for (genvar gi = 0; gi < 2; gi++) begin : g_deb
        coin_debounce #(
            .DEB_CNT (DEB_CNT)
        ) u_deb (
            .clk_sys (clk_sys),
            .reset_n (reset_n),
            .din     (coin_in[gi]),
            .dout    (w_coin_lvl[gi])
        );
    end
`else
    assign w_coin_lvl = coin_in;
`endif

    assign w_rise = w_coin_lvl & ~r_coin_prev;

    // A new pulse may start from IDLE or straight out of the final GAP cycle,
    // so back-to-back rising edges are exactly PULSE_CNT+GAP_CNT apart.
    assign w_launch = (r_q != 3'd0) && credit_light_n &&
                      ((r_state == IDLE) || ((r_state == GAP) && (r_cnt == c_gap_last)));

    assign w_q_sum = {1'b0, r_q} + {3'b000, w_rise[0]} + {3'b000, w_rise[1]}
                   - {3'b000, w_launch};

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_coin_prev <= 2'b00;
            r_q         <= 3'd0;
            r_overflow  <= 1'b0;
        end else begin
            r_coin_prev <= w_coin_lvl;
            if (w_q_sum > c_depth) begin
                r_q        <= c_depth[2:0];
                r_overflow <= 1'b1;
            end else begin
                r_q        <= w_q_sum[2:0];
                r_overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_coin_sw    <= 1'b0;
            r_start_game <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_launch) begin
                        r_state      <= PULSE;
                        r_cnt        <= '0;
                        r_coin_sw    <= 1'b1;
                        r_start_game <= 1'b0;
                    end else begin
                        r_start_game <= |start_in;
                    end
                end
                PULSE: begin
                    r_start_game <= 1'b0;
                    if (r_cnt == c_pulse_last) begin
                        r_state   <= GAP;
                        r_cnt     <= '0;
                        r_coin_sw <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_w'(1);
                    end
                end
                GAP: begin
                    r_start_game <= 1'b0;
                    if (r_cnt == c_gap_last) begin
                        r_cnt <= '0;
                        if (w_launch) begin
                            r_state   <= PULSE;
                            r_coin_sw <= 1'b1;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_cnt_w'(1);
                    end
                end
                default: begin
                    r_state      <= IDLE;
                    r_cnt        <= '0;
                    r_coin_sw    <= 1'b0;
                    r_start_game <= 1'b0;
                end
            endcase
        end
    end

    assign coin_sw    = r_coin_sw;
    assign start_game = r_start_game;
    assign pending    = r_q;
    assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_coin_sched.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_coin_sched
// Description : Self-checking bench for coin_sched (PULSE 8, GAP 4, DEPTH 4, DEB 3).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_coin_sched;

    localparam int c_pulse = 8;
    localparam int c_gap   = 4;

    logic       clk_sys        = 1'b0;
    logic       reset_n        = 1'b0;
    logic [1:0] coin_in        = 2'b00;
    logic [1:0] start_in       = 2'b00;
    logic       credit_light_n = 1'b1;
    logic       coin_sw;
    logic       start_game;
    logic [2:0] pending;
    logic       overflow;

    int cyc      = 0;
    int n_tests  = 0;
    int n_fail   = 0;
    int ovf_seen = 0;
    int rise_cyc = 0;
    int exp_rise[$];
    logic prev_sw = 1'b0;

    coin_sched #(
        .PULSE_CNT   (c_pulse),
        .GAP_CNT     (c_gap),
        .QUEUE_DEPTH (4),
        .DEB_CNT     (3)
    ) dut (
        .clk_sys        (clk_sys),
        .reset_n        (reset_n),
        .coin_in        (coin_in),
        .start_in       (start_in),
        .credit_light_n (credit_light_n),
        .coin_sw        (coin_sw),
        .start_game     (start_game),
        .pending        (pending),
        .overflow       (overflow)
    );

    always #5 clk_sys = ~clk_sys;
    always @(posedge clk_sys) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    // Pulse scoreboard: each rising edge of coin_sw must match the next expected cycle
    initial begin
        forever begin
            @(negedge clk_sys);
            if (!reset_n) begin
                prev_sw = 1'b0;
            end else begin
                if (overflow) ovf_seen++;
                if (coin_sw && !prev_sw) begin
                    rise_cyc = cyc;
                    if (exp_rise.size() == 0) check("unexpected_rise_cyc", 32'(cyc), 0);
                    else                      check("rise_cyc", 32'(cyc), 32'(exp_rise.pop_front()));
                end
                if (!coin_sw && prev_sw) check("pulse_width", 32'(cyc - rise_cyc), c_pulse);
                prev_sw = coin_sw;
            end
        end
    end

    initial begin
        int n;
        int m;
        int bad;

        repeat (3) tick();
        check("rst_coin_sw",    32'(coin_sw),    0);
        check("rst_start_game", 32'(start_game), 0);
        check("rst_pending",    32'(pending),    0);
        check("rst_overflow",   32'(overflow),   0);
        reset_n = 1'b1;
        repeat (2) tick();

`ifdef COIN_DEBOUNCE_EN
        // 2-cycle glitch must be swallowed
        coin_in = 2'b01;
        repeat (2) tick();
        coin_in = 2'b00;
        repeat (10) tick();
        check("deb_glitch_pending", 32'(pending), 0);

        // 5-cycle press: one event, pending 4 cycles after the rise
        n = cyc;
        coin_in = 2'b01;
        exp_rise.push_back(n + 5);
        repeat (3) tick();
        check("deb_pending_early", 32'(pending), 0);
        tick();
        check("deb_pending_lat4", 32'(pending), 1);
        tick();
        coin_in = 2'b00;
        repeat (30) tick();
        check("deb_pending_drained", 32'(pending), 0);
`else
        // Single coin, then a re-press that must wait out pulse plus gap
        n = cyc;
        coin_in = 2'b01;
        exp_rise.push_back(n + 2);
        tick();
        check("t1_pending_1", 32'(pending), 1);
        coin_in = 2'b00;
        tick();
        check("t1_pending_0", 32'(pending), 0);
        check("t1_coin_sw_hi", 32'(coin_sw), 1);
        tick();
        coin_in = 2'b01;
        exp_rise.push_back(n + c_pulse + c_gap + 2);
        tick();
        coin_in = 2'b00;
        repeat (30) tick();

        // Both buttons in one cycle
        n = cyc;
        coin_in = 2'b11;
        exp_rise.push_back(n + 2);
        exp_rise.push_back(n + 2 + c_pulse + c_gap);
        tick();
        check("t2_pending_2", 32'(pending), 2);
        coin_in = 2'b00;
        repeat (35) tick();

        // Six events with credit showing: saturate, two overflows, no pulses
        credit_light_n = 1'b0;
        ovf_seen = 0;
        for (int i = 0; i < 6; i++) begin
            coin_in = 2'b01;
            tick();
            coin_in = 2'b00;
            tick();
        end
        tick();
        check("t3_pending_sat", 32'(pending), 4);
        check("t3_overflow_strobes", 32'(ovf_seen), 2);
        m = cyc;
        credit_light_n = 1'b1;
        for (int i = 0; i < 4; i++) exp_rise.push_back(m + 1 + i * (c_pulse + c_gap));
        tick();
        check("t3_pending_after_deq", 32'(pending), 3);
        repeat (55) tick();
        check("t3_pending_drained", 32'(pending), 0);

        // Credit drops mid-pulse with two queued
        n = cyc;
        coin_in = 2'b11;
        exp_rise.push_back(n + 2);
        tick();
        coin_in = 2'b00;
        repeat (4) tick();
        credit_light_n = 1'b0;
        repeat (25) tick();
        check("t4_pending_held", 32'(pending), 1);
        check("t4_coin_sw_low", 32'(coin_sw), 0);
        m = cyc;
        credit_light_n = 1'b1;
        exp_rise.push_back(m + 1);
        repeat (20) tick();

        // Start held through a pulse
        start_in = 2'b01;
        repeat (2) tick();
        check("t5_start_idle", 32'(start_game), 1);
        n = cyc;
        coin_in = 2'b01;
        exp_rise.push_back(n + 2);
        tick();
        coin_in = 2'b00;
        check("t5_start_before_launch", 32'(start_game), 1);
        bad = 0;
        for (int i = 0; i <= c_pulse + c_gap; i++) begin
            tick();
            if (start_game !== 1'b0) bad++;
        end
        check("t5_start_blocked", 32'(bad), 0);
        tick();
        check("t5_start_back", 32'(start_game), 1);
        start_in = 2'b00;
        repeat (5) tick();

        // Reset in the middle of a pulse
        n = cyc;
        coin_in = 2'b11;
        exp_rise.push_back(n + 2);
        tick();
        coin_in = 2'b00;
        repeat (4) tick();
        reset_n = 1'b0;
        #1;
        check("t6_async_coin_sw", 32'(coin_sw), 0);
        check("t6_async_pending", 32'(pending), 0);
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        n = cyc;
        coin_in = 2'b01;
        exp_rise.push_back(n + 2);
        tick();
        coin_in = 2'b00;
        repeat (20) tick();
        check("t6_pending_end", 32'(pending), 0);
`endif

        check("scoreboard_empty", 32'(exp_rise.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
